// File: rtl/wb_deserializer.sv
// Writeback collector: rebuilds a 2*HALF_W word from two serialized halves, holds it on the
// register-file write port until granted, and exports the in-flight destination for hazard checks.
module wb_deserializer #(
  parameter int HALF_W      = 16,
  parameter bit SUPPRESS_X0 = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [HALF_W-1:0]     half_i,
  input  logic                  first_half_i,
  input  logic                  upper_first_i,
  input  logic [4:0]            rd_i,
  input  logic                  rf_write_i,
  input  logic                  rf_grant_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [2*HALF_W-1:0]   rf_wdata_o,
  output logic                  pending_valid_o,
  output logic [4:0]            pending_rd_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {S_EMPTY, S_HALF, S_FULL} state_t;

  state_t                state_q;
  logic [HALF_W-1:0]     first_q;
  logic                  upper_q;
  logic [4:0]            rd_q;
  logic                  need_q;
  logic                  rf_we_q;
  logic [4:0]            waddr_q;
  logic [2*HALF_W-1:0]   wdata_q;
  logic                  pend_vld_q;
  logic [4:0]            pend_rd_q;
  logic                  err_q;

  logic                  accept;
  logic                  need_d;
  logic [4:0]            pend_rd_d;
  logic [2*HALF_W-1:0]   word_d;

  // In FULL the slot frees on the same edge the write completes, so a granted cycle can accept.
  assign ready_o   = (state_q != S_FULL) || rf_grant_i;
  assign accept    = valid_i && ready_o;
  assign need_d    = rf_write_i && !(SUPPRESS_X0 && (rd_i == 5'd0));
  assign pend_rd_d = need_d ? rd_i : 5'd0;
  assign word_d    = upper_q ? {first_q, half_i} : {half_i, first_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      first_q    <= '0;
      upper_q    <= 1'b0;
      rd_q       <= '0;
      need_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      pend_vld_q <= 1'b0;
      pend_rd_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            if (first_half_i) begin
              first_q    <= half_i;
              upper_q    <= upper_first_i;
              rd_q       <= rd_i;
              need_q     <= need_d;
              pend_vld_q <= need_d;
              pend_rd_q  <= pend_rd_d;
              state_q    <= S_HALF;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_HALF: begin
          if (accept) begin
            if (first_half_i) begin
              // Restart: the stale half is discarded and the new instruction takes over.
              first_q    <= half_i;
              upper_q    <= upper_first_i;
              rd_q       <= rd_i;
              need_q     <= need_d;
              pend_vld_q <= need_d;
              pend_rd_q  <= pend_rd_d;
              err_q      <= 1'b1;
            end else if (need_q) begin
              rf_we_q <= 1'b1;
              waddr_q <= rd_q;
              wdata_q <= word_d;
              state_q <= S_FULL;
            end else begin
              state_q <= S_EMPTY;
            end
          end
        end
        S_FULL: begin
          if (rf_grant_i) begin
            rf_we_q <= 1'b0;
            if (valid_i && first_half_i) begin
              first_q    <= half_i;
              upper_q    <= upper_first_i;
              rd_q       <= rd_i;
              need_q     <= need_d;
              pend_vld_q <= need_d;
              pend_rd_q  <= pend_rd_d;
              state_q    <= S_HALF;
            end else begin
              pend_vld_q <= 1'b0;
              pend_rd_q  <= 5'd0;
              err_q      <= valid_i;
              state_q    <= S_EMPTY;
            end
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign rf_we_o         = rf_we_q;
  assign rf_waddr_o      = waddr_q;
  assign rf_wdata_o      = wdata_q;
  assign pending_valid_o = pend_vld_q;
  assign pending_rd_o    = pend_rd_q;
  assign err_o           = err_q;

endmodule

// File: doc/wb_deserializer.md
Name: wb_deserializer

Overview:
- Writeback collector at the tail of the 16-bit serialized execute datapath.
- Accepts two result halves per instruction from the execute stage, lower-first or upper-first, and reassembles the 32-bit word.
- Presents the word to the shared register-file write port and holds it until granted.
- Exports the pending destination register so the decode stage can detect read-after-write hazards.

Parameters:
- HALF_W, 16, width of one serialized half; word width is 2*HALF_W.
- SUPPRESS_X0, 1, when 1 a write targeting register 0 never asserts rf_we_o.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; asynchronous assert, active-low.
- valid_i  in  1  a result half is offered this cycle.
- ready_o  out  1  block accepts the offered half this cycle.
- half_i  in  HALF_W  result half data.
- first_half_i  in  1  offered half is the first of its instruction.
- upper_first_i  in  1  sampled with the first half; 1 means the first half is bits [31:16].
- rd_i  in  5  destination register, sampled with the first half.
- rf_write_i  in  1  instruction writes the register file, sampled with the first half.
- rf_grant_i  in  1  register-file port granted to this block this cycle.
- rf_we_o  out  1  write request.
- rf_waddr_o  out  5  write address.
- rf_wdata_o  out  2*HALF_W  assembled word.
- pending_valid_o  out  1  an in-flight instruction will write pending_rd_o.
- pending_rd_o  out  5  destination of the in-flight instruction.
- err_o  out  1  one-cycle pulse on a half-sequence protocol violation.

Behaviour:
- Accept event: valid_i && ready_o at a rising edge.
- States:
  - EMPTY: no half held.
  - HALF: one half held.
  - FULL: word assembled; waits for the port when a write is needed.
- ready_o: 1 in EMPTY and HALF; in FULL equals rf_grant_i. The combinational grant-to-ready path is allowed.
- Needs write: rf_write_i (latched) && !(SUPPRESS_X0 && rd==0).
- EMPTY:
  - Accept with first_half_i=1: store half, upper_first, rd, rf_write; go to HALF.
  - Accept with first_half_i=0: drop the half, pulse err_o next cycle, stay in EMPTY.
- HALF:
  - Accept with first_half_i=0: place the first half and the new half per upper_first to form the word.
  - If needs write: go to FULL with rf_we_o=1 next cycle.
  - Otherwise: go to EMPTY with no write.
- HALF, accept with first_half_i=1: discard the held half, pulse err_o, restart with the new half as first half (latch new rd/flags), stay in HALF.
- FULL:
  - rf_we_o=1 with stable address and data until a cycle with rf_grant_i=1; the write completes at that edge.
  - Same edge, a first half is accepted: go to HALF. Otherwise go to EMPTY.
  - Accepting a non-first half in that cycle drops it, pulses err_o, and goes to EMPTY.
- Latency: second half accepted at edge N, so rf_we_o=1 during cycle N+1. With grant held high, throughput is one instruction per two cycles with no bubble.
- Hazard outputs:
  - pending_valid_o=1 in HALF and FULL when needs write; 0 in EMPTY.
  - pending_rd_o holds the latched rd, or 0 when invalid.
  - Both are registered and change only at accept or write-complete edges.
- rf_wdata_o and rf_waddr_o hold their last value when rf_we_o=0.
- Reset (asynchronous, any time, including mid-instruction):
  - State EMPTY; rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, pending_valid_o=0, pending_rd_o=0, err_o=0.
  - ready_o=1 from the first cycle after deassertion.
  - A partially held instruction is lost silently.
- rf_grant_i outside FULL is ignored.

Test Plan:
- Lower-first: rd=5, rf_write=1, halves 0xBEEF then 0xDEAD, grant tied 1 -> rf_we_o one cycle after the second accept, waddr=5, wdata=0xDEADBEEF. pending_valid_o=1, pending_rd_o=5 from the first accept until write complete.
- Upper-first (upper_first_i=1): halves 0x1234 then 0x5678 -> wdata=0x12345678.
- Grant stall: grant low for 3 cycles in FULL -> rf_we_o/wdata stable, ready_o=0. Next instruction (rd=7) offered with grant rising -> write completes and the first half is accepted on the same edge. State HALF, pending_rd_o=7.
- Suppression: rd=0 with rf_write=1 (SUPPRESS_X0=1), and separately rd=9 with rf_write=0 -> no rf_we_o, pending_valid_o=0, state returns to EMPTY after the second half.
- Protocol errors:
  - In EMPTY, a non-first half 0xAAAA -> err_o pulses once, nothing written.
  - In HALF (rd=3), a new first half with rd=4 arrives -> err_o pulses; the following second half writes rd=4 with the new halves only.
- Reset mid-operation: assert rst_n low while in HALF and again while in FULL with grant low -> all outputs 0 immediately, no write ever issued, ready_o=1 after release.
